// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_if
// Description : Program-load, fetch-control and instruction-delivery signals
//               between a processor (master) and the fetch unit (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if;
    logic        load_en;
    logic [9:0]  load_addr;
    logic [31:0] load_data;
    logic        run;
    logic        stall;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        halted;
    logic        fault;

    modport master (
        output load_en, load_addr, load_data, run, stall, redirect_en, redirect_pc,
        input  instruction, pc_out, instr_valid, halted, fault
    );

    modport slave (
        input  load_en, load_addr, load_data, run, stall, redirect_en, redirect_pc,
        output instruction, pc_out, instr_valid, halted, fault
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch unit with loadable program memory. Loads in
//               IDLE, streams one word per cycle in RUN (1-cycle read latency),
//               honours stall/redirect, stops on HALT_WORD or a bad address.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic         clk,
    input  logic         rst,
    instr_fetch_if.slave bus
);

    localparam int c_ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      r_state, w_state;
    logic [31:0] r_pc, w_pc;
    logic [31:0] r_instr, w_instr;
    logic [31:0] r_pc_out, w_pc_out;
    logic        r_valid, w_valid;
    logic        r_halted, w_halted;
    logic        r_fault, w_fault;
    logic        w_mem_we;
    logic        w_in_range;
    logic [31:0] w_rd_word;
    logic [31:0] r_mem [DEPTH];

    // Full 32-bit compare so that a pc past the end never aliases back into memory
    assign w_in_range = (r_pc >> 2) < 32'(DEPTH);
    assign w_rd_word  = r_mem[r_pc[c_ADDR_W+1:2]];

    // Next-state and next-output decode; every register holds unless a case below moves it
    always_comb begin
        w_state  = r_state;
        w_pc     = r_pc;
        w_instr  = r_instr;
        w_pc_out = r_pc_out;
        w_valid  = r_valid;
        w_halted = r_halted;
        w_fault  = r_fault;
        w_mem_we = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.load_en) begin
                    w_mem_we = 1'b1;
                end else if (bus.run) begin
                    w_state = S_RUN;
                    w_pc    = RESET_PC;
                end
            end
            S_RUN: begin
                if (bus.redirect_en) begin
                    // The word read this cycle belongs to the wrong path: drop it
                    w_valid = 1'b0;
                    if (bus.redirect_pc[1:0] != 2'b00) begin
                        w_state  = S_HALT;
                        w_halted = 1'b1;
                        w_fault  = 1'b1;
                    end else begin
                        w_pc = bus.redirect_pc;
                    end
                end else if (bus.stall) begin
                    // Processor busy: presented word and fetch pointer both freeze
                    w_pc = r_pc;
                end else if (!w_in_range) begin
                    w_state  = S_HALT;
                    w_halted = 1'b1;
                    w_fault  = 1'b1;
                    w_valid  = 1'b0;
                end else if (w_rd_word == HALT_WORD) begin
                    w_state  = S_HALT;
                    w_halted = 1'b1;
                    w_valid  = 1'b0;
                end else begin
                    w_instr  = w_rd_word;
                    w_pc_out = r_pc;
                    w_valid  = 1'b1;
                    w_pc     = r_pc + 32'd4;
                end
            end
            S_HALT: begin
                w_valid = 1'b0;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset overrides every control input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_instr  <= 32'd0;
            r_pc_out <= 32'd0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_pc     <= w_pc;
            r_instr  <= w_instr;
            r_pc_out <= w_pc_out;
            r_valid  <= w_valid;
            r_halted <= w_halted;
            r_fault  <= w_fault;
        end
    end

    // Program memory write port; contents survive reset so a program can be rerun
    always_ff @(posedge clk) begin
        if (!rst && w_mem_we) begin
            r_mem[bus.load_addr[c_ADDR_W-1:0]] <= bus.load_data;
        end
    end

    assign bus.instruction = r_instr;
    assign bus.pc_out      = r_pc_out;
    assign bus.instr_valid = r_valid;
    assign bus.halted      = r_halted;
    assign bus.fault       = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Scoreboard bench for instr_fetch: the driver pushes the
//               expected fetch outcome from a program-level model, the
//               monitor pops and compares whenever the DUT presents a result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam int          DEPTH     = 16;
    localparam int          AW        = 4;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] { K_INSTR, K_HALT, K_FAULT } kind_e;
    typedef struct {
        kind_e       kind;
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_if bus ();
    instr_fetch_if bus4 ();

    instr_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .HALT_WORD(HALT_WORD)) dut (
        .clk(clk), .rst(rst), .bus(bus));
    instr_fetch #(.DEPTH(4), .RESET_PC(RESET_PC), .HALT_WORD(HALT_WORD)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4));

    int          n_checks = 0;
    int          n_pass   = 0;
    exp_t        sb [$];
    logic [31:0] model_mem [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name, input string detail);
        n_checks++;
        $display("FAIL %s: %s at %0t", name, detail, $time);
    endtask

    // What fetching byte address a yields, from the program contents alone
    function automatic exp_t model_fetch(input logic [31:0] a);
        exp_t e;
        e.pc   = a;
        e.word = 32'd0;
        if (a[1:0] != 2'b00)                 e.kind = K_FAULT;
        else if ((a >> 2) >= 32'(DEPTH))     e.kind = K_FAULT;
        else if (model_mem[a[AW+1:2]] == HALT_WORD) e.kind = K_HALT;
        else begin
            e.kind = K_INSTR;
            e.word = model_mem[a[AW+1:2]];
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w = $urandom;
        if (w == HALT_WORD) w = 32'd0;
        return w;
    endfunction

    function automatic logic [31:0] rand_target();
        int unsigned sel = $urandom_range(9);
        int unsigned idx = $urandom_range(DEPTH - 1);
        if (sel == 0) return (idx << 2) | $urandom_range(3, 1);
        if (sel == 1) return ($urandom_range(1) == 0) ? 32'hFFFF_FFFC
                                                      : (32'(DEPTH) + $urandom_range(100)) << 2;
        return idx << 2;
    endfunction

    task automatic idle_inputs();
        bus.load_en     = 1'b0;
        bus.load_addr   = 10'd0;
        bus.load_data   = 32'd0;
        bus.run         = 1'b0;
        bus.stall       = 1'b0;
        bus.redirect_en = 1'b0;
        bus.redirect_pc = 32'd0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_instruction"}, bus.instruction, 32'd0);
        check({tag, "_pc_out"},      bus.pc_out, 32'd0);
        check({tag, "_valid"},       32'(bus.instr_valid), 32'd0);
        check({tag, "_halted"},      32'(bus.halted), 32'd0);
        check({tag, "_fault"},       32'(bus.fault), 32'd0);
    endtask

    // Reset with every other control asserted, including a load that must not land
    task automatic do_reset();
        @(negedge clk);
        rst             = 1'b1;
        bus.load_en     = 1'b1;
        bus.load_addr   = 10'd0;
        bus.load_data   = 32'hDEAD_BEEF;
        bus.run         = 1'b1;
        bus.stall       = 1'b1;
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 32'h4;
        sb.delete();
        @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        idle_inputs();
    endtask

    // Address aliases above DEPTH exercise the modulo on load_addr
    task automatic load_model();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            bus.load_en   = 1'b1;
            bus.load_addr = 10'(i + DEPTH * $urandom_range(63));
            bus.load_data = model_mem[i];
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic run_prog(input int hold, input bit first_redir, input logic [31:0] first_target,
                            input int stall_pct, input int redir_pct, input int max_redir,
                            input int abort_at, input bit junk_load);
        logic [31:0] cur, t;
        logic        s, r;
        int          cycles, consumed, nredir, hold_left;
        bit          aborted;
        @(negedge clk);
        bus.run = 1'b1;
        sb.push_back(model_fetch(RESET_PC));
        cur = RESET_PC;
        @(negedge clk);
        bus.run   = 1'b0;
        cycles    = 0;
        consumed  = 0;
        nredir    = 0;
        hold_left = hold;
        aborted   = 1'b0;
        while (!bus.halted && !aborted && cycles < 600) begin
            if (abort_at > 0 && consumed >= abort_at) begin
                rst             = 1'b1;
                bus.stall       = 1'b1;
                bus.redirect_en = 1'b1;
                bus.redirect_pc = 32'h8;
                bus.load_en     = 1'b1;
                bus.load_data   = $urandom;
                sb.delete();
                @(negedge clk);
                check_reset_vals("mid_run_reset");
                rst = 1'b0;
                idle_inputs();
                aborted = 1'b1;
            end else begin
                s = ($urandom_range(99) < stall_pct);
                r = 1'b0;
                t = $urandom;
                if (bus.instr_valid) begin
                    if (consumed == 0 && hold_left > 0) begin
                        s = 1'b1;
                        hold_left--;
                    end else if (consumed == 0 && first_redir) begin
                        r = 1'b1;
                        t = first_target;
                    end else if (nredir < max_redir && $urandom_range(99) < redir_pct) begin
                        r = 1'b1;
                        t = rand_target();
                    end
                    if (r) begin
                        nredir++;
                        consumed++;
                        cur = t;
                        sb.push_back(model_fetch(cur));
                    end else if (!s) begin
                        consumed++;
                        cur = cur + 32'd4;
                        sb.push_back(model_fetch(cur));
                    end
                end
                bus.stall       = s;
                bus.redirect_en = r;
                bus.redirect_pc = t;
                bus.load_en     = junk_load && ($urandom_range(3) == 0);
                bus.load_addr   = 10'($urandom);
                bus.load_data   = $urandom;
                @(negedge clk);
                cycles++;
            end
        end
        if (!aborted) begin
            if (!bus.halted) fail_now("run_timeout", "halted never asserted within 600 cycles");
            idle_inputs();
            @(negedge clk);
            check("sb_drained", 32'(sb.size()), 32'd0);
        end
    endtask

    // Monitor: compares every fresh presentation and every stop against the scoreboard
    initial begin : monitor
        exp_t        e;
        logic        a_rst, a_stall, a_redir;
        logic        prev_valid, prev_halted;
        logic [31:0] last_pc, last_word;
        prev_valid  = 1'b0;
        prev_halted = 1'b0;
        last_pc     = 32'd0;
        last_word   = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            a_rst   = rst;
            a_stall = bus.stall;
            a_redir = bus.redirect_en;
            if (a_rst) begin
                prev_valid  = 1'b0;
                prev_halted = 1'b0;
                last_pc     = 32'd0;
                last_word   = 32'd0;
            end else begin
                if (bus.instr_valid) begin
                    if (prev_valid && a_stall && !a_redir) begin
                        check("stall_hold_instr", bus.instruction, last_word);
                        check("stall_hold_pc", bus.pc_out, last_pc);
                    end else if (sb.size() == 0) begin
                        fail_now("valid_unexpected", $sformatf("got pc_out %08h, expected no instruction", bus.pc_out));
                    end else begin
                        e = sb.pop_front();
                        if (e.kind != K_INSTR) begin
                            fail_now("valid_instead_of_stop", $sformatf("got instr %08h pc %08h, expected stop (fault=%0d)",
                                     bus.instruction, bus.pc_out, e.kind == K_FAULT));
                        end else begin
                            check("instr_word", bus.instruction, e.word);
                            check("instr_pc", bus.pc_out, e.pc);
                            last_pc   = e.pc;
                            last_word = e.word;
                        end
                    end
                end
                if (prev_valid && a_redir)
                    check("redirect_bubble", 32'(bus.instr_valid), 32'd0);
                if (prev_valid && !a_stall && !a_redir && !bus.halted)
                    check("throughput", 32'(bus.instr_valid), 32'd1);
                if (bus.halted && !prev_halted) begin
                    if (sb.size() == 0) begin
                        fail_now("stop_unexpected", "got halted=1, expected no stop");
                    end else begin
                        e = sb.pop_front();
                        if (e.kind == K_INSTR) begin
                            fail_now("stop_early", $sformatf("got halted=1, expected instr %08h at pc %08h", e.word, e.pc));
                        end else begin
                            check("stop_fault", 32'(bus.fault), (e.kind == K_FAULT) ? 32'd1 : 32'd0);
                            check("stop_pc_out", bus.pc_out, last_pc);
                        end
                    end
                    check("stop_valid", 32'(bus.instr_valid), 32'd0);
                end
                prev_valid  = bus.instr_valid;
                prev_halted = bus.halted;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL global_timeout: got no end of test, expected completion before 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [31:0] w4 [4];
        idle_inputs();
        bus4.load_en = 1'b0; bus4.load_addr = 10'd0; bus4.load_data = 32'd0; bus4.run = 1'b0;
        bus4.stall = 1'b0; bus4.redirect_en = 1'b0; bus4.redirect_pc = 32'd0;
        do_reset();
        do_reset();

        // Small add/sw/halt program, straight through
        for (int i = 0; i < DEPTH; i++) model_mem[i] = rand_word();
        model_mem[0] = 32'h0022_1820;
        model_mem[1] = 32'hAC22_0002;
        model_mem[2] = HALT_WORD;
        load_model();
        run_prog(0, 1'b0, 32'd0, 0, 0, 0, 0, 1'b0);

        // Same program, first instruction held by a 3-cycle stall
        do_reset();
        run_prog(3, 1'b0, 32'd0, 0, 0, 0, 0, 1'b0);

        // Sequential words, branch to 8 while word 0 is presented
        do_reset();
        for (int i = 0; i < 4; i++) model_mem[i] = 32'h1000_0000 + 32'(i);
        load_model();
        run_prog(0, 1'b1, 32'h8, 0, 0, 0, 0, 1'b0);

        // Misaligned branch target faults; a load attempted in HALT must be ignored
        do_reset();
        run_prog(0, 1'b1, 32'h6, 0, 0, 0, 0, 1'b0);
        @(negedge clk);
        bus.load_en   = 1'b1;
        bus.load_addr = 10'd0;
        bus.load_data = 32'h1234_5678;
        @(negedge clk);
        idle_inputs();
        do_reset();
        do_reset();
        run_prog(0, 1'b0, 32'd0, 0, 0, 0, 0, 1'b0);

        // Reset lands mid-run with stall and redirect both asserted
        do_reset();
        run_prog(0, 1'b0, 32'd0, 0, 0, 0, 2, 1'b0);

        // Random programs with random stalls, branches and stray loads
        repeat (12) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] = rand_word();
            if ($urandom_range(9) < 7) model_mem[$urandom_range(DEPTH - 1)] = HALT_WORD;
            do_reset();
            load_model();
            run_prog(0, 1'b0, 32'd0, 30, 15, 4, 0, 1'b1);
        end

        // Four-word memory without a halt word runs off the end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            w4[i] = $urandom & 32'h7FFF_FFFF;
            @(negedge clk);
            bus4.load_en   = 1'b1;
            bus4.load_addr = 10'(i);
            bus4.load_data = w4[i];
        end
        @(negedge clk);
        bus4.load_en = 1'b0;
        bus4.run     = 1'b1;
        @(negedge clk);
        bus4.run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("d4_valid", 32'(bus4.instr_valid), 32'd1);
            check("d4_word", bus4.instruction, w4[i]);
            check("d4_pc", bus4.pc_out, 32'(i * 4));
        end
        @(negedge clk);
        check("d4_end_valid", 32'(bus4.instr_valid), 32'd0);
        check("d4_end_halted", 32'(bus4.halted), 32'd1);
        check("d4_end_fault", 32'(bus4.fault), 32'd1);
        check("d4_end_pc_out", bus4.pc_out, 32'hC);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
